two_complement_decode_serial: RTL and testbench
===============================================

Name: two_complement_decode_serial

Overview:
- Bit-serial decoder that converts an N-bit two's-complement word into sign-magnitude form.
- It is the inverse-direction companion to the combinational negation converter in the converters group.
- It sits between a two's-complement datapath and sign-magnitude consumers such as display and BCD formatting logic.
- It trades latency for area: one bit is processed per clock, with valid/ready handshakes on both sides.

Parameters:
- N, default 4: input word width in bits (N >= 2).
- CNT_W, default $clog2(N): width of the bit counter. Derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  decoder can accept a word.
- in_data  in  N  two's-complement input word.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sign  out  1  sign of the result (1 = negative).
- out_mag  out  N-1  magnitude.
- out_ovf  out  1  magnitude not representable in N-1 bits (input = -2^(N-1)).
- busy  out  1  conversion in progress (state SHIFT).

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high, sampled on the rising edge of clk.
  - While rst=1: state=IDLE, in_ready=1, out_valid=0, out_sign=0, out_mag=0, out_ovf=0, busy=0, counter=0, shift/result registers=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, at the clock edge:
    - latch sign=in_data[N-1];
    - load the shift register with in_data;
    - clear seen_one and the counter;
    - go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - Each cycle processes one bit b = shift register LSB:
    - if sign=0: result bit = b;
    - if sign=1: result bit = seen_one ? ~b : b, and seen_one <= seen_one | b.
  - The result bit shifts into the result register MSB-side; the shift register shifts right; the counter increments.
  - When counter==N-1 at the edge, go to DONE. Exactly N SHIFT cycles.
- DONE:
  - out_valid=1.
  - out_sign=sign; out_mag=result[N-2:0]; out_ovf=sign & result[N-1].
  - Outputs are held stable until out_valid&&out_ready, then go to IDLE with out_valid=0.
  - Output values stay at their last result (not cleared) until the next DONE.
- Latency:
  - out_valid rises N clocks after the accepting edge.
  - Minimum issue interval is N+2 cycles (no IDLE bypass).
- Timing is constant: positive inputs and zero also take N SHIFT cycles.
- Boundary conditions:
  - Zero input: sign=0, mag=0, ovf=0.
  - Input -2^(N-1): sign=1, ovf=1, mag per the optional feature.
  - in_valid while in SHIFT or DONE: ignored, not latched. The upstream holds the word because in_ready=0.
  - out_ready high while not in DONE: no effect.
  - rst asserted mid-conversion or in DONE: the conversion is aborted, all outputs return to reset values on that edge, and the result is discarded.
  - rst and in_valid in the same cycle: reset wins, nothing is accepted.

Optional Feature:
- Macro: TWO_COMPLEMENT_DECODE_SAT_EN
- Defined: when out_ovf=1, out_mag saturates to all ones (2^(N-1)-1).
- Undefined: when out_ovf=1, out_mag = result[N-2:0], which is all zeros.
- out_ovf is present and identical in both builds.

Decomposition:
- Shared package two_complement_pkg:
  - state enum/localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - counter width helper function;
  - most-negative constant function min_neg(N).
- One natural sub-module: serial_negate_cell.
  - Combinational per-bit copy/invert cell.
  - Inputs: b, sign, seen_one.
  - Outputs: result bit, next seen_one.
  - Instantiated once; the FSM holds the seen_one register.

Test Plan (N=4):
1. Reset held 2 cycles, then released -> in_ready=1, out_valid=0, out_mag=0, out_sign=0, out_ovf=0, busy=0.
2. in_data=4'b1111 (-1) accepted -> out_valid rises exactly 4 clocks later with sign=1, mag=3'b001, ovf=0; held until out_ready.
3. in_data=4'b0110 (+6), then 4'b1110 (-2) back-to-back with out_ready=1 -> results sign=0, mag=3'b110, then sign=1, mag=3'b010; second word accepted only after the return to IDLE.
4. in_data=4'b1000 (-8) -> sign=1, ovf=1; mag=3'b111 with TWO_COMPLEMENT_DECODE_SAT_EN, 3'b000 without.
5. in_data=4'b0000 -> sign=0, mag=0, ovf=0 after 4 clocks; in_valid toggled during SHIFT with other data -> ignored, result unchanged.
6. rst pulsed on the 2nd SHIFT cycle of in_data=4'b1011 -> all outputs at reset values the next cycle; a following 4'b0011 converts to sign=0, mag=3'b011.

Source files
------------

// File: rtl/two_complement_pkg.sv
// Shared definitions for the bit-serial two's-complement to sign-magnitude
// decoder: FSM state encoding, counter sizing and the most-negative constant.
package two_complement_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit-counter width for an n-bit word; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Unsigned bit pattern of -2^(n-1) in an n-bit word (MSB set, rest zero).
  function automatic longint unsigned min_neg(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/serial_negate_cell.sv
// Per-bit copy/invert cell of the serial two's-complement negation:
// bits are copied up to and including the first 1 seen from the LSB,
// every later bit is inverted. Positive words pass through unchanged.
module serial_negate_cell (
  input  logic b,
  input  logic sign,
  input  logic seen_one,
  output logic result_bit,
  output logic seen_one_next
);

  assign result_bit    = (sign & seen_one) ? ~b : b;
  assign seen_one_next = sign ? (seen_one | b) : seen_one;

endmodule

// File: rtl/two_complement_decode_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder, one bit per clock,
// valid/ready handshakes on both sides. Fixed latency of N clocks from accept
// to out_valid regardless of the input value.
// Optional build macro TWO_COMPLEMENT_DECODE_SAT_EN: when the input is the most
// negative value (out_ovf=1) the magnitude saturates to all ones instead of
// the raw all-zero pattern.
module two_complement_decode_serial
  import two_complement_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sign,
  output logic [N-2:0] out_mag,
  output logic         out_ovf,
  output logic         busy
);

  localparam int CNT_W = cnt_width(N);

  state_t             state_reg;
  state_t             state_next;
  logic               sign_reg;
  logic               seen_one_reg;
  logic [N-1:0]       shift_reg;
  logic [N-1:0]       result_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               out_sign_reg;
  logic               out_ovf_reg;
  logic [N-2:0]       out_mag_reg;

  logic               bit_res;
  logic               seen_one_next;
  logic               accept;
  logic               last_bit;
  logic [N-1:0]       result_next;
  logic               ovf_next;
  logic [N-2:0]       mag_next;

  serial_negate_cell u_cell (
    .b             (shift_reg[0]),
    .sign          (sign_reg),
    .seen_one      (seen_one_reg),
    .result_bit    (bit_res),
    .seen_one_next (seen_one_next)
  );

  assign accept      = in_valid && (state_reg == IDLE);
  assign last_bit    = (state_reg == SHIFT) && (cnt_reg == CNT_W'(N - 1));
  // New bits enter at the MSB so after N shifts the first bit sits at bit 0.
  assign result_next = {bit_res, result_reg[N-1:1]};
  // Only -2^(N-1) leaves the top result bit set for a negative input.
  assign ovf_next    = sign_reg & result_next[N-1];

`ifdef TWO_COMPLEMENT_DECODE_SAT_EN
  assign mag_next = ovf_next ? {(N-1){1'b1}} : result_next[N-2:0];
`else
  assign mag_next = result_next[N-2:0];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic and state-decoded handshake/status outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, shift one bit per SHIFT cycle, capture the
  // result into the output registers on the final bit so they hold until
  // the next conversion completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_reg     <= 1'b0;
      seen_one_reg <= 1'b0;
      shift_reg    <= '0;
      result_reg   <= '0;
      cnt_reg      <= '0;
      out_sign_reg <= 1'b0;
      out_ovf_reg  <= 1'b0;
      out_mag_reg  <= '0;
    end else if (accept) begin
      sign_reg     <= in_data[N-1];
      shift_reg    <= in_data;
      seen_one_reg <= 1'b0;
      result_reg   <= '0;
      cnt_reg      <= '0;
    end else if (state_reg == SHIFT) begin
      result_reg   <= result_next;
      shift_reg    <= shift_reg >> 1;
      seen_one_reg <= seen_one_next;
      cnt_reg      <= cnt_reg + 1'b1;
      if (last_bit) begin
        out_sign_reg <= sign_reg;
        out_ovf_reg  <= ovf_next;
        out_mag_reg  <= mag_next;
      end
    end
  end

  assign out_sign = out_sign_reg;
  assign out_mag  = out_mag_reg;
  assign out_ovf  = out_ovf_reg;

endmodule

// File: tb/tb_two_complement_decode_serial.sv
// Scoreboard bench for two_complement_decode_serial (N=4). Expected results
// come from a signed-integer reference model; a negedge monitor compares.
module tb_two_complement_decode_serial;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_sign;
  logic [N-2:0] out_mag;
  logic         out_ovf;
  logic         busy;

  two_complement_decode_serial #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sign;
    logic [N-2:0] mag;
    logic         ovf;
    int           acc;
    logic [N-1:0] din;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;
  bit   rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain signed arithmetic on the input word.
  function automatic exp_t model(input logic [N-1:0] d);
    exp_t e;
    int v;
    int a;
    v = d[N-1] ? (int'(d) - (1 << N)) : int'(d);
    a = (v < 0) ? -v : v;
    e.sign = (v < 0);
    e.ovf  = (a == (1 << (N - 1)));
`ifdef TWO_COMPLEMENT_DECODE_SAT_EN
    e.mag  = e.ovf ? (N-1)'((1 << (N - 1)) - 1) : (N-1)'(a);
`else
    e.mag  = e.ovf ? '0 : (N-1)'(a);
`endif
    e.acc = 0;
    e.din = d;
    return e;
  endfunction

  // Drive a word, wait (bounded) for acceptance, queue its expected result.
  task automatic send(input logic [N-1:0] d, output int acc);
    exp_t e;
    logic rdy;
    int   waitc = 0;
    acc = -1;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      waitc++;
      if (waitc > 200) begin
        tests++; fails++;
        $display("FAIL accept_timeout: got no in_ready expected accept of %0h", d);
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = N'($urandom);
    if (rdy) begin
      acc = cyc;
      e = model(d);
      e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_sign"},  out_sign,  0);
    check({tag, "_out_mag"},   out_mag,   0);
    check({tag, "_out_ovf"},   out_ovf,   0);
    check({tag, "_busy"},      busy,      0);
  endtask

  // Randomised consumer back-pressure.
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compare the presented result every cycle it is valid, pop on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output: got sign=%0d mag=%0d ovf=%0d expected none", out_sign, out_mag, out_ovf);
      end else begin
        if (!prev_valid) check("latency", cyc - q[0].acc, N);
        check("sign", out_sign, q[0].sign);
        check("mag",  out_mag,  q[0].mag);
        check("ovf",  out_ovf,  q[0].ovf);
        if (out_ready) begin
          $display("[TB] in=%b -> sign=%0d mag=%b ovf=%0d", q[0].din, out_sign, out_mag, out_ovf);
          void'(q.pop_front());
        end
      end
    end
    prev_valid = out_valid;
  end

  initial begin
    int a0;
    int a1;
    int waitc;

    // 1. reset held for two cycles, then released
    rst = 1'b1;
    idle_cycles(2);
    check_reset_values("rst_held");
    rst = 1'b0;
    idle_cycles(1);
    check_reset_values("rst_rel");

    // 2. -1 with consumer stalled: result must hold until out_ready
    out_ready = 1'b0;
    send(4'b1111, a0);
    waitc = 0;
    while (!out_valid && waitc < 50) begin idle_cycles(1); waitc++; end
    check("neg1_valid_seen", out_valid, 1);
    idle_cycles(3);
    check("neg1_held", out_valid, 1);
    out_ready = 1'b1;
    idle_cycles(1);
    check("neg1_released", out_valid, 0);

    // 3. back-to-back +6, -2 with out_ready high; issue interval N+2
    send(4'b0110, a0);
    send(4'b1110, a1);
    check("issue_interval", a1 - a0, N + 2);

    // 4. most negative value
    send(4'b1000, a0);

    // 5. zero, with in_valid toggling during SHIFT (must be ignored)
    send(4'b0000, a0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = N'($urandom_range(1, 15));
      check("shift_busy", busy, 1);
      check("shift_in_ready", in_ready, 0);
      idle_cycles(1);
    end
    in_valid = 1'b0;
    idle_cycles(N + 2);

    // 6. reset during the second SHIFT cycle aborts the conversion
    send(4'b1011, a0);
    idle_cycles(1);
    rst = 1'b1;
    q.delete();
    idle_cycles(1);
    rst = 1'b0;
    check_reset_values("rst_mid");
    send(4'b0011, a0);
    idle_cycles(N + 3);

    // reset and in_valid together: nothing accepted
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 4'b0101;
    idle_cycles(1);
    in_valid = 1'b0;
    rst = 1'b0;
    check("rst_wins_busy", busy, 0);
    check("rst_wins_in_ready", in_ready, 1);

    // randomized traffic with random consumer back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      idle_cycles($urandom_range(0, 2));
      send(N'($urandom), a0);
    end

    // drain (bounded)
    waitc = 0;
    while (q.size() != 0 && waitc < 2000) begin idle_cycles(1); waitc++; end
    check("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
